rmii_rx_fcs: RTL

Parametrised RMII receive front end: recovers octets from the PHY dibit stream at 100 Mb/s or 10 Mb/s, strips preamble/SFD and writes header, body and FCS bytes to the downstream RX FIFO. Adds on-the-fly CRC-32 check, min/max length check and clean mid-frame overflow truncation. Every frame end is tagged with a good/bad flag. Sits between the RMII pins and the RX FIFO in the REF_CLK domain; the gray-coded counters feed the system-clock monitor.

---
 rtl/rmii_pkg.sv | 27 ++
 rtl/bin2gray.sv | 16 +
 rtl/crc32_dibit.sv | 29 ++
 rtl/rmii_rx_fcs.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rmii_pkg.sv
`default_nettype none
// ============================================================================
// rmii_pkg : shared constants for the RMII receive path (FSM codes, SFD, CRC)
// Revision : 1.0
// ============================================================================
package rmii_pkg;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREAMBLE = 3'd1;
    localparam logic [2:0] S_BODY     = 3'd2;
    localparam logic [2:0] S_END      = 3'd3;
    localparam logic [2:0] S_ALIGN    = 3'd4;
    localparam logic [2:0] S_DROP     = 3'd5;

    localparam logic [7:0]  SFD         = 8'hD5;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    // Index of each statistics counter in the counter array
    localparam int CNT_SUCC    = 0;
    localparam int CNT_BUFF_OF = 1;
    localparam int CNT_FCS_ERR = 2;
    localparam int CNT_LEN_ERR = 3;

endpackage
`default_nettype wire

// File: rtl/bin2gray.sv
`default_nettype none
// ============================================================================
// bin2gray : binary to reflected-gray code converter
// Revision : 1.0
// ============================================================================
module bin2gray #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_bin,
    output logic [W-1:0] o_gray
);

    assign o_gray = i_bin ^ (i_bin >> 1);

endmodule
`default_nettype wire

// File: rtl/crc32_dibit.sv
`default_nettype none
// ============================================================================
// crc32_dibit : combinational reflected CRC-32 step over one dibit (bit0 first)
// Revision    : 1.0
// ============================================================================
module crc32_dibit
    import rmii_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [1:0]  i_dibit,
    output logic [31:0] o_crc
);

    logic [31:0] w_crc;

    always_comb begin
        w_crc = i_crc;
        for (int i = 0; i < 2; i++) begin
            if (w_crc[0] ^ i_dibit[i])
                w_crc = {1'b0, w_crc[31:1]} ^ CRC_POLY;
            else
                w_crc = {1'b0, w_crc[31:1]};
        end
    end

    assign o_crc = w_crc;

endmodule
`default_nettype wire

// File: rtl/rmii_rx_fcs.sv
`default_nettype none
// ============================================================================
// rmii_rx_fcs : RMII receive front end with CRC-32, length and overflow checks
// Revision    : 1.0
// ============================================================================
module rmii_rx_fcs
    import rmii_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1522,
    parameter int CNT_W   = 16,
    parameter int LEN_W   = 11
) (
    input  logic             REF_CLK,
    input  logic             arst_n,
    input  logic [1:0]       RXD,
    input  logic             CRS_DV,
    input  logic             speed_10,
    input  logic             fifo_afull,
    output logic [7:0]       fifo_din,
    output logic             fifo_wren,
    output logic             fifo_EOD_in,
    output logic             fifo_ERR_in,
    output logic [CNT_W-1:0] succ_rx_count_gray,
    output logic [CNT_W-1:0] buff_OF_count_gray,
    output logic [CNT_W-1:0] fcs_err_count_gray,
    output logic [CNT_W-1:0] len_err_count_gray
);

    localparam logic [LEN_W-1:0] c_LEN_MIN   = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] c_LEN_TRUNC = LEN_W'(MAX_LEN + 1);
    localparam logic [3:0]       c_DIV_LAST  = 4'd9;
    localparam logic [3:0]       c_DIV_SEN   = 4'd4;

    logic [1:0]       r_rxd, r_rxd_d;
    logic             r_crs, r_crs_d;
    logic [3:0]       r_div;
    logic [2:0]       r_state, w_state_nxt;
    logic [7:0]       r_seq;
    logic [1:0]       r_dib_cnt;
    logic [LEN_W-1:0] r_len;
    logic [31:0]      r_crc;
    logic             r_oct_rdy, r_crc_bad, r_runt;
    logic [CNT_W-1:0] r_cnt  [4];
    logic [CNT_W-1:0] w_gray [4];
    logic [3:0]       w_inc;

    logic             w_sen, w_dv, w_wr_body, w_wr_align;
    logic             w_crc_bad, w_runt, w_trunc_len;
    logic [7:0]       w_seq_nxt;
    logic [31:0]      w_crc_nxt;
    logic [LEN_W-1:0] w_len_nxt;

    // The dibit under evaluation is the delayed one, so its DV in 100M mode
    // can look at its own CRS_DV and the following one (nibble toggling).
    assign w_sen       = speed_10 ? (r_div == c_DIV_SEN) : 1'b1;
    assign w_dv        = speed_10 ? r_crs_d : (r_crs_d | r_crs);
    assign w_seq_nxt   = {r_rxd_d, r_seq[7:2]};
    assign w_len_nxt   = (r_len == c_LEN_TRUNC) ? r_len : r_len + 1'b1;
    assign w_crc_bad   = (r_crc != CRC_RESIDUE);
    assign w_runt      = (w_len_nxt < c_LEN_MIN);
    assign w_trunc_len = (w_len_nxt == c_LEN_TRUNC);

    // A completed octet is written on the sen after its last dibit
    assign w_wr_body  = (r_state == S_BODY) && r_oct_rdy && w_sen;
    assign w_wr_align = (r_state == S_ALIGN) && (r_len != '0);

    assign fifo_wren   = w_wr_body | w_wr_align;
    assign fifo_din    = w_wr_body ? r_seq : 8'h00;
    assign fifo_EOD_in = w_wr_align | (w_wr_body & (fifo_afull | w_trunc_len | ~w_dv));
    assign fifo_ERR_in = w_wr_align |
                         (w_wr_body & (fifo_afull | w_trunc_len | (~w_dv & (w_crc_bad | w_runt))));

    crc32_dibit u_crc (
        .i_crc   (r_crc),
        .i_dibit (r_rxd_d),
        .o_crc   (w_crc_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_inc       = '0;
        case (r_state)
            S_IDLE: begin
                if (r_crs) begin
                    if (fifo_afull) begin
                        w_inc[CNT_BUFF_OF] = 1'b1;
                        w_state_nxt        = S_DROP;
                    end else begin
                        w_state_nxt = S_PREAMBLE;
                    end
                end
            end
            S_PREAMBLE: begin
                if (w_sen) begin
                    if (!w_dv)                   w_state_nxt = S_IDLE;
                    else if (w_seq_nxt == SFD)   w_state_nxt = S_BODY;
                end
            end
            S_BODY: begin
                if (w_sen) begin
                    if (r_oct_rdy) begin
                        if (fifo_afull) begin
                            w_inc[CNT_BUFF_OF] = 1'b1;
                            w_state_nxt        = S_DROP;
                        end else if (w_trunc_len) begin
                            w_inc[CNT_LEN_ERR] = 1'b1;
                            w_state_nxt        = S_DROP;
                        end else if (!w_dv) begin
                            w_state_nxt = S_END;
                        end
                    end else if (!w_dv) begin
                        w_state_nxt = S_ALIGN;
                    end
                end
            end
            S_END: begin
                w_state_nxt = S_IDLE;
                if (r_runt)          w_inc[CNT_LEN_ERR] = 1'b1;
                else if (r_crc_bad)  w_inc[CNT_FCS_ERR] = 1'b1;
                else                 w_inc[CNT_SUCC]    = 1'b1;
            end
            S_ALIGN: begin
                w_state_nxt = S_IDLE;
                if (r_len != '0) w_inc[CNT_FCS_ERR] = 1'b1;
            end
            S_DROP: begin
                if (w_sen && !w_dv) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_DROP;
        endcase
    end

    always_ff @(posedge REF_CLK or negedge arst_n) begin
        if (!arst_n) begin
            r_rxd     <= '0;
            r_rxd_d   <= '0;
            r_crs     <= 1'b0;
            r_crs_d   <= 1'b0;
            r_div     <= '0;
            r_state   <= S_IDLE;
            r_seq     <= '0;
            r_dib_cnt <= '0;
            r_len     <= '0;
            r_crc     <= CRC_INIT;
            r_oct_rdy <= 1'b0;
            r_crc_bad <= 1'b0;
            r_runt    <= 1'b0;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            r_rxd   <= RXD;
            r_crs   <= CRS_DV;
            r_rxd_d <= r_rxd;
            r_crs_d <= r_crs;
            r_state <= w_state_nxt;

            if ((r_state == S_IDLE) && r_crs)  r_div <= '0;
            else if (r_div == c_DIV_LAST)      r_div <= '0;
            else                               r_div <= r_div + 1'b1;

            if (w_sen) r_seq <= w_seq_nxt;

            if (r_state == S_PREAMBLE) begin
                r_dib_cnt <= '0;
                r_len     <= '0;
                r_crc     <= CRC_INIT;
                r_oct_rdy <= 1'b0;
            end else if ((r_state == S_BODY) && w_sen) begin
                if (w_wr_body) r_len <= w_len_nxt;
                if (w_dv) begin
                    r_crc     <= w_crc_nxt;
                    r_dib_cnt <= r_dib_cnt + 1'b1;
                    r_oct_rdy <= (r_dib_cnt == 2'd3);
                end else begin
                    r_oct_rdy <= 1'b0;
                end
                if (w_wr_body && !w_dv) begin
                    r_crc_bad <= w_crc_bad;
                    r_runt    <= w_runt;
                end
            end

            for (int i = 0; i < 4; i++)
                if (w_inc[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
        end
    end

    generate
        for (genvar g = 0; g < 4; g++) begin : g_gray
            bin2gray #(.W(CNT_W)) u_b2g (
                .i_bin  (r_cnt[g]),
                .o_gray (w_gray[g])
            );
        end
    endgenerate

    assign succ_rx_count_gray = w_gray[CNT_SUCC];
    assign buff_OF_count_gray = w_gray[CNT_BUFF_OF];
    assign fcs_err_count_gray = w_gray[CNT_FCS_ERR];
    assign len_err_count_gray = w_gray[CNT_LEN_ERR];

endmodule
`default_nettype wire
